// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 phase sequencer and its memory mux.
// Phase encoding doubles as the mux select and the externally visible phase output.
package rc4_pkg;

    localparam int KEY_WIDTH  = 24;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam int WD_WIDTH   = 16;

    typedef enum logic [3:0] {
        IDLE,
        INIT_GO,
        INIT_WAIT,
        KSA_GO,
        KSA_WAIT,
        PRGA_GO,
        PRGA_WAIT,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    function automatic phase_t state_phase(input state_t s);
        phase_t p;
        case (s)
            INIT_GO, INIT_WAIT: p = PH_INIT;
            KSA_GO, KSA_WAIT:   p = PH_KSA;
            PRGA_GO, PRGA_WAIT: p = PH_PRGA;
            default:            p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rc4_sequencer_if.sv
// Bundle of control, phase handshake and S-memory request signals around the sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface rc4_sequencer_if;
    import rc4_pkg::*;

    logic                  start;
    logic [KEY_WIDTH-1:0]  secret_key;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [1:0]            phase;

    logic                  init_start;
    logic                  ksa_start;
    logic                  prga_start;
    logic                  init_finish;
    logic                  ksa_finish;
    logic                  prga_finish;

    logic [ADDR_WIDTH-1:0] init_address;
    logic [ADDR_WIDTH-1:0] ksa_address;
    logic [ADDR_WIDTH-1:0] prga_address;
    logic [DATA_WIDTH-1:0] init_data;
    logic [DATA_WIDTH-1:0] ksa_data;
    logic [DATA_WIDTH-1:0] prga_data;
    logic                  init_wren;
    logic                  ksa_wren;
    logic                  prga_wren;

    logic [KEY_WIDTH-1:0]  ksa_secret_key;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_wren;

    modport slave (
        input  start, secret_key,
        input  init_finish, ksa_finish, prga_finish,
        input  init_address, ksa_address, prga_address,
        input  init_data, ksa_data, prga_data,
        input  init_wren, ksa_wren, prga_wren,
        output busy, done, error, phase,
        output init_start, ksa_start, prga_start,
        output ksa_secret_key,
        output mem_address, mem_data, mem_wren
    );

    modport master (
        output start, secret_key,
        output init_finish, ksa_finish, prga_finish,
        output init_address, ksa_address, prga_address,
        output init_data, ksa_data, prga_data,
        output init_wren, ksa_wren, prga_wren,
        input  busy, done, error, phase,
        input  init_start, ksa_start, prga_start,
        input  ksa_secret_key,
        input  mem_address, mem_data, mem_wren
    );

endinterface

// File: rtl/s_mem_mux.sv
// Combinational S-memory port selector: only the phase that currently owns the
// memory reaches it; with no owner the port is held at all zeros.
module s_mem_mux
    import rc4_pkg::*;
(
    input  phase_t                phase,
    input  logic [ADDR_WIDTH-1:0] init_address,
    input  logic [ADDR_WIDTH-1:0] ksa_address,
    input  logic [ADDR_WIDTH-1:0] prga_address,
    input  logic [DATA_WIDTH-1:0] init_data,
    input  logic [DATA_WIDTH-1:0] ksa_data,
    input  logic [DATA_WIDTH-1:0] prga_data,
    input  logic                  init_wren,
    input  logic                  ksa_wren,
    input  logic                  prga_wren,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren
);

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        case (phase)
            PH_INIT: begin
                mem_address = init_address;
                mem_data    = init_data;
                mem_wren    = init_wren;
            end
            PH_KSA: begin
                mem_address = ksa_address;
                mem_data    = ksa_data;
                mem_wren    = ksa_wren;
            end
            PH_PRGA: begin
                mem_address = prga_address;
                mem_data    = prga_data;
                mem_wren    = prga_wren;
            end
            default: begin
                mem_address = '0;
                mem_data    = '0;
                mem_wren    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_sequencer.sv
// Runs the init, KSA and PRGA phase FSMs in order, owns the shared S-memory port
// and watches each phase with a saturating watchdog.
module rc4_sequencer
    import rc4_pkg::*;
#(
    parameter int TIMEOUT = 4095
) (
    input  logic clock,
    input  logic reset,
    rc4_sequencer_if.slave bus
);

    localparam logic [WD_WIDTH-1:0] TIMEOUT_LIMIT = WD_WIDTH'(TIMEOUT);

    state_t               state_reg;
    state_t               state_next;
    logic [WD_WIDTH-1:0]  wd_reg;
    logic [WD_WIDTH-1:0]  wd_next;
    logic [WD_WIDTH-1:0]  wd_inc;
    logic                 wd_expired;
    logic [KEY_WIDTH-1:0] key_reg;
    logic [KEY_WIDTH-1:0] key_next;

    phase_t               phase_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 error_reg;
    logic                 init_start_reg;
    logic                 ksa_start_reg;
    logic                 prga_start_reg;

    // wd_inc is the count including the current WAIT cycle; hitting the limit
    // here means this cycle is the last one the phase is allowed.
    assign wd_inc     = (wd_reg == '1) ? wd_reg : wd_reg + 1'b1;
    assign wd_expired = (wd_inc >= TIMEOUT_LIMIT);

    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        wd_next    = '0;
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (bus.start) begin
                    state_next = INIT_GO;
                    key_next   = bus.secret_key;
                end
            end
            INIT_GO: state_next = INIT_WAIT;
            INIT_WAIT: begin
                if (bus.init_finish) begin
                    state_next = KSA_GO;
                end else if (wd_expired) begin
                    state_next = ERROR;
                end else begin
                    wd_next = wd_inc;
                end
            end
            KSA_GO: state_next = KSA_WAIT;
            KSA_WAIT: begin
                if (bus.ksa_finish) begin
                    state_next = PRGA_GO;
                end else if (wd_expired) begin
                    state_next = ERROR;
                end else begin
                    wd_next = wd_inc;
                end
            end
            PRGA_GO: state_next = PRGA_WAIT;
            PRGA_WAIT: begin
                if (bus.prga_finish) begin
                    state_next = DONE;
                end else if (wd_expired) begin
                    state_next = ERROR;
                end else begin
                    wd_next = wd_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are loaded from state_next so each register always equals
    // the decode of the current state while never looking at an input directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            wd_reg         <= '0;
            key_reg        <= '0;
            phase_reg      <= PH_NONE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            init_start_reg <= 1'b0;
            ksa_start_reg  <= 1'b0;
            prga_start_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wd_reg         <= wd_next;
            key_reg        <= key_next;
            phase_reg      <= state_phase(state_next);
            busy_reg       <= (state_phase(state_next) != PH_NONE);
            done_reg       <= (state_next == DONE);
            error_reg      <= (state_next == ERROR);
            init_start_reg <= (state_next == INIT_GO);
            ksa_start_reg  <= (state_next == KSA_GO);
            prga_start_reg <= (state_next == PRGA_GO);
        end
    end

    assign bus.busy           = busy_reg;
    assign bus.done           = done_reg;
    assign bus.error          = error_reg;
    assign bus.phase          = phase_reg;
    assign bus.init_start     = init_start_reg;
    assign bus.ksa_start      = ksa_start_reg;
    assign bus.prga_start     = prga_start_reg;
    assign bus.ksa_secret_key = key_reg;

    s_mem_mux u_s_mem_mux (
        .phase        (phase_reg),
        .init_address (bus.init_address),
        .ksa_address  (bus.ksa_address),
        .prga_address (bus.prga_address),
        .init_data    (bus.init_data),
        .ksa_data     (bus.ksa_data),
        .prga_data    (bus.prga_data),
        .init_wren    (bus.init_wren),
        .ksa_wren     (bus.ksa_wren),
        .prga_wren    (bus.prga_wren),
        .mem_address  (bus.mem_address),
        .mem_data     (bus.mem_data),
        .mem_wren     (bus.mem_wren)
    );

endmodule
